// File: rtl/matrix_loader.sv
// Streams DIM*DIM matrix elements followed by DIM vector elements from a
// valid/ready source into separate A and B write ports, one cycle after accept.
module matrix_loader #(
  parameter int DIM        = 64,
  parameter int DATA_WIDTH = 8,
  localparam int A_AW      = $clog2(DIM * DIM),
  localparam int B_AW      = $clog2(DIM)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  wr_en_a,
  output logic [A_AW-1:0]       wr_addr_a,
  output logic [DATA_WIDTH-1:0] wr_data_a,
  output logic                  wr_en_b,
  output logic [B_AW-1:0]       wr_addr_b,
  output logic [DATA_WIDTH-1:0] wr_data_b,
  output logic                  done,
  output logic [15:0]           elem_count,
  output logic [15:0]           checksum
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_DONE
  } state_t;

  localparam logic [A_AW-1:0] A_LAST = A_AW'(DIM * DIM - 1);
  localparam logic [B_AW-1:0] B_LAST = B_AW'(DIM - 1);

  state_t                state_reg, state_next;
  logic [A_AW-1:0]       idx_a_reg, idx_a_next;
  logic [B_AW-1:0]       idx_b_reg, idx_b_next;
  logic [15:0]           count_reg, count_next;
  logic [15:0]           sum_reg, sum_next;
  logic                  wr_en_a_reg, wr_en_a_next;
  logic                  wr_en_b_reg, wr_en_b_next;
  logic [A_AW-1:0]       wr_addr_a_reg, wr_addr_a_next;
  logic [B_AW-1:0]       wr_addr_b_reg, wr_addr_b_next;
  logic [DATA_WIDTH-1:0] wr_data_a_reg, wr_data_a_next;
  logic [DATA_WIDTH-1:0] wr_data_b_reg, wr_data_b_next;
  logic                  accept;

  // Ready depends on registered state only, so it never loops back through in_valid.
  assign in_ready = (state_reg == S_LOAD_A) || (state_reg == S_LOAD_B);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      idx_a_reg     <= '0;
      idx_b_reg     <= '0;
      count_reg     <= '0;
      sum_reg       <= '0;
      wr_en_a_reg   <= 1'b0;
      wr_en_b_reg   <= 1'b0;
      wr_addr_a_reg <= '0;
      wr_addr_b_reg <= '0;
      wr_data_a_reg <= '0;
      wr_data_b_reg <= '0;
    end else begin
      state_reg     <= state_next;
      idx_a_reg     <= idx_a_next;
      idx_b_reg     <= idx_b_next;
      count_reg     <= count_next;
      sum_reg       <= sum_next;
      wr_en_a_reg   <= wr_en_a_next;
      wr_en_b_reg   <= wr_en_b_next;
      wr_addr_a_reg <= wr_addr_a_next;
      wr_addr_b_reg <= wr_addr_b_next;
      wr_data_a_reg <= wr_data_a_next;
      wr_data_b_reg <= wr_data_b_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    idx_a_next     = idx_a_reg;
    idx_b_next     = idx_b_reg;
    count_next     = count_reg;
    sum_next       = sum_reg;
    wr_en_a_next   = 1'b0;
    wr_en_b_next   = 1'b0;
    wr_addr_a_next = wr_addr_a_reg;
    wr_addr_b_next = wr_addr_b_reg;
    wr_data_a_next = wr_data_a_reg;
    wr_data_b_next = wr_data_b_reg;

    if (accept) begin
      count_next = (count_reg == 16'hFFFF) ? count_reg : count_reg + 16'd1;
      sum_next   = sum_reg + 16'(in_data);
    end

    case (state_reg)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_next = S_LOAD_A;
          idx_a_next = '0;
          idx_b_next = '0;
          count_next = '0;
          sum_next   = '0;
        end
      end
      S_LOAD_A: begin
        if (accept) begin
          wr_en_a_next   = 1'b1;
          wr_addr_a_next = idx_a_reg;
          wr_data_a_next = in_data;
          idx_a_next     = idx_a_reg + 1'b1;
          if (idx_a_reg == A_LAST) begin
            state_next = S_LOAD_B;
          end
        end
      end
      S_LOAD_B: begin
        if (accept) begin
          wr_en_b_next   = 1'b1;
          wr_addr_b_next = idx_b_reg;
          wr_data_b_next = in_data;
          idx_b_next     = idx_b_reg + 1'b1;
          if (idx_b_reg == B_LAST) begin
            state_next = S_DONE;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign wr_en_a    = wr_en_a_reg;
  assign wr_addr_a  = wr_addr_a_reg;
  assign wr_data_a  = wr_data_a_reg;
  assign wr_en_b    = wr_en_b_reg;
  assign wr_addr_b  = wr_addr_b_reg;
  assign wr_data_b  = wr_data_b_reg;
  assign done       = (state_reg == S_DONE);
  assign elem_count = count_reg;
  assign checksum   = sum_reg;

endmodule

// File: tb/tb_matrix_loader.sv
// Scoreboard bench for matrix_loader at DIM=4: the driver queues every expected
// write, and a negedge monitor pops and compares each write the DUT emits.
module tb_matrix_loader;
  localparam int DIM = 4;
  localparam int DW  = 8;
  localparam int NA  = DIM * DIM;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic          wr_en_a;
  logic [3:0]    wr_addr_a;
  logic [DW-1:0] wr_data_a;
  logic          wr_en_b;
  logic [1:0]    wr_addr_b;
  logic [DW-1:0] wr_data_b;
  logic          done;
  logic [15:0]   elem_count;
  logic [15:0]   checksum;

  always #5 clock = ~clock;

  matrix_loader #(.DIM(DIM), .DATA_WIDTH(DW)) dut (
    .clock(clock), .reset(reset), .start(start),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .wr_en_a(wr_en_a), .wr_addr_a(wr_addr_a), .wr_data_a(wr_data_a),
    .wr_en_b(wr_en_b), .wr_addr_b(wr_addr_b), .wr_data_b(wr_data_b),
    .done(done), .elem_count(elem_count), .checksum(checksum)
  );

  typedef struct {
    bit is_b;
    int addr;
    int data;
    int cyc;
  } exp_t;

  exp_t q[$];
  int cyc = 0;
  int n_assert = 0;
  int n_fail = 0;
  int exp_idx = 0;
  int exp_count = 0;
  int exp_sum = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_assert++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every write must match the head of the scoreboard, including its cycle.
  always @(negedge clock) begin
    exp_t e;
    if (wr_en_a || wr_en_b) begin
      check("wr_en exclusive", int'(wr_en_a && wr_en_b), 0);
      if (wr_en_b) $display("write B[%0d] = %0d at cycle %0d", wr_addr_b, wr_data_b, cyc);
      else         $display("write A[%0d] = %0d at cycle %0d", wr_addr_a, wr_data_a, cyc);
      if (q.size() == 0) begin
        check("unexpected write", 1, 0);
      end else begin
        e = q.pop_front();
        check("write port", int'(wr_en_b), int'(e.is_b));
        check("write addr", wr_en_b ? int'(wr_addr_b) : int'(wr_addr_a), e.addr);
        check("write data", wr_en_b ? int'(wr_data_b) : int'(wr_data_a), e.data);
        check("write cycle", cyc, e.cyc);
      end
    end
  end

  task automatic model_clear();
    exp_idx   = 0;
    exp_count = 0;
    exp_sum   = 0;
  endtask

  task automatic send(input logic [DW-1:0] d);
    exp_t e;
    @(negedge clock);
    check("in_ready while loading", int'(in_ready), 1);
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    e.is_b   = (exp_idx >= NA);
    e.addr   = (exp_idx >= NA) ? exp_idx - NA : exp_idx;
    e.data   = int'(d);
    e.cyc    = cyc + 1;
    q.push_back(e);
    exp_idx++;
    if (exp_count < 65535) exp_count++;
    exp_sum = (exp_sum + int'(d)) & 16'hFFFF;
  endtask

  task automatic bubble();
    @(negedge clock);
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic do_start();
    @(negedge clock);
    in_valid = 1'b0;
    start    = 1'b1;
    @(negedge clock);
    start = 1'b0;
    model_clear();
    check("done after start", int'(done), 0);
    check("elem_count after start", int'(elem_count), 0);
    check("checksum after start", int'(checksum), 0);
  endtask

  task automatic check_done(input string tag);
    bubble();
    check({tag, " done"}, int'(done), 1);
    check({tag, " elem_count"}, int'(elem_count), exp_count);
    check({tag, " checksum"}, int'(checksum), exp_sum);
  endtask

  task automatic check_reset_state();
    check("reset in_ready", int'(in_ready), 0);
    check("reset wr_en_a", int'(wr_en_a), 0);
    check("reset wr_en_b", int'(wr_en_b), 0);
    check("reset wr_addr_a", int'(wr_addr_a), 0);
    check("reset wr_addr_b", int'(wr_addr_b), 0);
    check("reset wr_data_a", int'(wr_data_a), 0);
    check("reset wr_data_b", int'(wr_data_b), 0);
    check("reset done", int'(done), 0);
    check("reset elem_count", int'(elem_count), 0);
    check("reset checksum", int'(checksum), 0);
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(negedge clock);
    check_reset_state();
    reset = 1'b0;

    // Back-to-back stream 1..20.
    do_start();
    for (int i = 1; i <= 20; i++) send(DW'(i));
    check_done("burst");
    check("burst checksum 210", exp_sum, 210);

    // Same stream with a bubble after every element.
    do_start();
    for (int i = 1; i <= 20; i++) begin
      send(DW'(i));
      bubble();
    end
    check_done("bubbled");

    // Abort after 7 accepts; a handshake coinciding with reset must not write.
    do_start();
    for (int i = 1; i <= 7; i++) send(DW'(i));
    @(negedge clock);
    in_valid = 1'b1;
    in_data  = 8'hAA;
    reset    = 1'b1;
    @(negedge clock);
    reset    = 1'b0;
    in_valid = 1'b0;
    check_reset_state();
    do_start();
    for (int i = 0; i < 20; i++) send(8'hFF);
    check_done("after abort");
    check("after abort checksum 5100", exp_sum, 5100);

    // start during LOAD_A is ignored.
    do_start();
    for (int i = 1; i <= 3; i++) send(DW'(i));
    @(negedge clock);
    in_valid = 1'b0;
    start    = 1'b1;
    for (int i = 4; i <= 20; i++) send(DW'(i));
    check_done("start ignored");

    // Held valid in DONE is refused; write ports hold their last values.
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      in_valid = 1'b1;
      in_data  = 8'h55;
      check("done in_ready", int'(in_ready), 0);
      check("done level", int'(done), 1);
      check("done elem_count", int'(elem_count), 20);
    end
    check("hold wr_addr_a", int'(wr_addr_a), 15);
    check("hold wr_data_a", int'(wr_data_a), 16);
    check("hold wr_addr_b", int'(wr_addr_b), 3);
    check("hold wr_data_b", int'(wr_data_b), 20);
    do_start();
    check("restart in_ready", int'(in_ready), 1);

    repeat (4) bubble();
    check("scoreboard drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
